inv_sub_bytes_seq: RTL



---
 rtl/aes_pkg.sv | 19 +
 rtl/inv_sbox.sv | 29 ++
 rtl/inv_sub_bytes_seq.sv | 88 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and the byte-order helper.
// Byte 0 is the most significant byte of a 128-bit state.
package aes_pkg;

    localparam int unsigned STATE_W     = 128;
    localparam int unsigned STATE_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_state_t;

    function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] state,
                                            input int unsigned        idx);
        return state[STATE_W-1-8*idx -: 8];
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box: combinational 8-bit lookup over all 256 entries.
module inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0x00 is the top byte; entry k sits at bit offset 8*(255-k).
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign o_byte = INV_SBOX[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes engine: substitutes LANES bytes per cycle in place,
// with valid/ready handshakes on both the input and output side.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    localparam int unsigned STEPS = STATE_BYTES / LANES;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [STATE_W-1:0] r_data;

    logic [7:0]         w_sb_in  [LANES];
    logic [7:0]         w_sb_out [LANES];
    logic [STATE_W-1:0] w_data_sub;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_sb_in[l] = get_byte(r_data, 32'(r_cnt) * LANES + 32'(l));

        inv_sbox u_inv_sbox (
            .i_byte (w_sb_in[l]),
            .o_byte (w_sb_out[l])
        );
    end

    // Only the LANES bytes selected by r_cnt are replaced; the rest pass through.
    always_comb begin
        w_data_sub = r_data;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_data_sub[STATE_W-1-8*(32'(r_cnt)*LANES+l) -: 8] = w_sb_out[l];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_data <= w_data_sub;
                    if (r_cnt == CNT_W'(STEPS - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_data;

endmodule
